// File: rtl/result_reader_pkg.sv
// Shared definitions for the result-area reader: FSM encoding and the
// result-record layout written by the checker.
package result_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_HI  = 3'd1,
    ST_RD_LO  = 3'd2,
    ST_DECODE = 3'd3,
    ST_PUSH   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [7:0] META_RUN     = 8'h80;
  localparam int         FAIL_BIT     = 0;
  localparam int         RECORD_WORDS = 2;

endpackage

// File: rtl/result_unpack.sv
// Combinational decoder: word pair {hi, lo} -> {fail, run, result vector}.
module result_unpack
  import result_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int RTF_WIDTH  = 24
) (
  input  logic [DATA_WIDTH-1:0] hi,
  input  logic [DATA_WIDTH-1:0] lo,
  output logic                  fail,
  output logic                  run,
  output logic [RTF_WIDTH-1:0]  vector
);

  logic [7:0] meta;

  assign meta   = lo[7:0];
  assign fail   = meta[FAIL_BIT];
  assign run    = (meta & META_RUN) == META_RUN;
  assign vector = {hi, lo[DATA_WIDTH-1:8]};

endmodule

// File: rtl/result_reader.sv
// Avalon-MM read master that walks the result area and unpacks two-word
// records into {fail, vector} FIFO words. Optional: RESULT_READER_FAIL_ONLY_EN.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int RTF_WIDTH  = 24,
  parameter int CNT_WIDTH  = 16,
  parameter int OUT_WIDTH  = RTF_WIDTH + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_records,
  output logic                  busy,
  output logic                  done,
  output logic                  truncated,
  output logic [CNT_WIDTH-1:0]  rec_count,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_waitrequest,
  output logic [OUT_WIDTH-1:0]  ofifo_data,
  output logic                  ofifo_wrreq,
  input  logic                  ofifo_wrfull,
  output logic [2:0]            dbg_state
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [CNT_WIDTH-1:0]  rec_count_q;
  logic [CNT_WIDTH-1:0]  fail_count_q;
  logic                  truncated_q;

  logic                  rec_fail;
  logic                  rec_run;
  logic [RTF_WIDTH-1:0]  rec_vector;
  logic                  rd_ack;
  logic                  push_fire;

  result_unpack #(
    .DATA_WIDTH(DATA_WIDTH),
    .RTF_WIDTH (RTF_WIDTH)
  ) u_unpack (
    .hi    (hi_q),
    .lo    (lo_q),
    .fail  (rec_fail),
    .run   (rec_run),
    .vector(rec_vector)
  );

  // Handshakes: a memory word transfers in a cycle with mem_read && !mem_waitrequest;
  // a FIFO word transfers in a cycle with ofifo_wrreq (never raised while ofifo_wrfull).
  // Address, strobe and FIFO data are register-driven and hold while stalled.
  assign mem_read       = (state_q == ST_RD_HI) || (state_q == ST_RD_LO);
  assign rd_ack         = mem_read && !mem_waitrequest;
  assign mem_address    = addr_q;
  assign mem_byteenable = '1;
  assign busy           = state_q != ST_IDLE;
  assign done           = state_q == ST_DONE;
  assign truncated      = truncated_q;
  assign rec_count      = rec_count_q;
  assign fail_count     = fail_count_q;
  assign ofifo_data     = {rec_fail, rec_vector};
  assign dbg_state      = state_q;

`ifdef RESULT_READER_FAIL_ONLY_EN
  // Passing records are counted but never written, so they cannot stall on a full FIFO.
  assign ofifo_wrreq = (state_q == ST_PUSH) && rec_fail && !ofifo_wrfull;
  assign push_fire   = (state_q == ST_PUSH) && (!rec_fail || !ofifo_wrfull);
`else
  assign ofifo_wrreq = (state_q == ST_PUSH) && !ofifo_wrfull;
  assign push_fire   = ofifo_wrreq;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      rec_count_q  <= '0;
      fail_count_q <= '0;
      truncated_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q       <= base_addr;
            remaining_q  <= num_records;
            rec_count_q  <= '0;
            fail_count_q <= '0;
            truncated_q  <= 1'b0;
            state_q      <= (num_records == '0) ? ST_DONE : ST_RD_HI;
          end
        end
        ST_RD_HI: begin
          if (rd_ack) begin
            hi_q    <= mem_readdata;
            addr_q  <= addr_q + 1'b1;
            state_q <= ST_RD_LO;
          end
        end
        ST_RD_LO: begin
          if (rd_ack) begin
            lo_q    <= mem_readdata;
            addr_q  <= addr_q + 1'b1;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!rec_run) begin
            truncated_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            state_q <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (push_fire) begin
            rec_count_q  <= rec_count_q + 1'b1;
            fail_count_q <= fail_count_q + {{(CNT_WIDTH-1){1'b0}}, rec_fail};
            remaining_q  <= remaining_q - 1'b1;
            state_q      <= (remaining_q == {{(CNT_WIDTH-1){1'b0}}, 1'b1}) ? ST_DONE : ST_RD_HI;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: memory responder with programmable wait states,
// record-level reference model, per-cycle compare process and directed runs.
module tb_result_reader;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int OW = 25;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_records = '0;
  logic          busy, done, truncated, mem_read, ofifo_wrreq;
  logic [CW-1:0] rec_count, fail_count;
  logic [AW-1:0] mem_address;
  logic [1:0]    mem_byteenable;
  logic [DW-1:0] mem_readdata = '0;
  logic          mem_waitrequest = 1'b0;
  logic [OW-1:0] ofifo_data;
  logic          ofifo_wrfull = 1'b0;
  logic [2:0]    dbg_state;

  result_reader dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .num_records    (num_records),
    .busy           (busy),
    .done           (done),
    .truncated      (truncated),
    .rec_count      (rec_count),
    .fail_count     (fail_count),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_read       (mem_read),
    .mem_readdata   (mem_readdata),
    .mem_waitrequest(mem_waitrequest),
    .ofifo_data     (ofifo_data),
    .ofifo_wrreq    (ofifo_wrreq),
    .ofifo_wrfull   (ofifo_wrfull),
    .dbg_state      (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_err(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none (t=%0t)", name, $time);
  endtask

  // ---------------- memory responder ----------------
  logic [DW-1:0] mem_arr [0:1023];
  int wait_n = 0;
  int wait_cnt = 0;

  always @(negedge clock) begin
    mem_readdata = mem_arr[mem_address[9:0]];
    if (mem_read && wait_cnt < wait_n) begin
      mem_waitrequest = 1'b1;
      wait_cnt++;
    end else begin
      mem_waitrequest = 1'b0;
      wait_cnt = 0;
    end
  end

  // ---------------- reference model ----------------
  logic [OW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int   exp_rec, exp_fail;
  logic exp_trunc;

  // Walk the records exactly as the checker laid them down: stop at the first
  // record without the run marker, otherwise emit {fail, 24-bit vector}.
  task automatic model_run(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] w0, w1;
    exp_q.delete();
    exp_addr_q.delete();
    exp_rec   = 0;
    exp_fail  = 0;
    exp_trunc = 1'b0;
    for (int i = 0; i < n; i++) begin
      a0 = base + AW'(2 * i);
      a1 = a0 + 1'b1;
      w0 = mem_arr[a0[9:0]];
      w1 = mem_arr[a1[9:0]];
      exp_addr_q.push_back(a0);
      exp_addr_q.push_back(a1);
      if (!w1[7]) begin
        exp_trunc = 1'b1;
        break;
      end
      exp_rec  = exp_rec + 1;
      exp_fail = exp_fail + int'(w1[0]);
`ifdef RESULT_READER_FAIL_ONLY_EN
      if (w1[0]) exp_q.push_back({w1[0], w0, w1[15:8]});
`else
      exp_q.push_back({w1[0], w0, w1[15:8]});
`endif
    end
  endtask

  // ---------------- compare process ----------------
  int first_rd_cyc = -1;
  int done_cyc = -1;
  int last_lo_cyc = -1;
  int acc_cnt = 0;
  int done_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clock) begin
    #1;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_read && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (mem_read && mem_waitrequest && prev_stall)
        chk("stall_addr_stable", 32'(mem_address), 32'(prev_addr));
      if (mem_read && !mem_waitrequest) begin
        if (exp_addr_q.size() == 0) flag_err("unexpected_read");
        else chk("read_addr", 32'(mem_address), 32'(exp_addr_q.pop_front()));
        acc_cnt++;
        if (acc_cnt % 2 == 0) last_lo_cyc = cyc;
      end
      prev_stall = mem_read && mem_waitrequest;
      prev_addr  = mem_address;
      if (ofifo_wrreq) begin
        chk("wrreq_while_full", 32'(ofifo_wrfull), 32'd0);
        if (exp_q.size() == 0) flag_err("unexpected_fifo_write");
        else chk("fifo_data", 32'(ofifo_data), 32'(exp_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_rec_count", 32'(rec_count), 32'(exp_rec));
        chk("done_fail_count", 32'(fail_count), 32'(exp_fail));
        chk("done_truncated", 32'(truncated), 32'(exp_trunc));
        chk("done_fifo_left", 32'(exp_q.size()), 32'd0);
        chk("done_reads_left", 32'(exp_addr_q.size()), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [AW-1:0] base, input int n, input int waits, output int st);
    model_run(base, n);
    wait_n       = waits;
    first_rd_cyc = -1;
    done_cyc     = -1;
    last_lo_cyc  = -1;
    acc_cnt      = 0;
    @(negedge clock);
    base_addr   = base;
    num_records = CW'(n);
    start       = 1'b1;
    st          = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int dc0);
    for (int k = 0; k < 3000 && done_cnt == dc0; k++) @(negedge clock);
    if (done_cnt == dc0) flag_err("done_timeout");
    @(negedge clock);
    #2;
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_truncated"}, 32'(truncated), 32'd0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_wrreq"}, 32'(ofifo_wrreq), 32'd0);
    chk({tag, "_mem_address"}, 32'(mem_address), 32'd0);
    chk({tag, "_rec_count"}, 32'(rec_count), 32'd0);
    chk({tag, "_fail_count"}, 32'(fail_count), 32'd0);
    chk({tag, "_ofifo_data"}, 32'(ofifo_data), 32'd0);
    chk({tag, "_byteenable"}, 32'(mem_byteenable), 32'h3);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int st, dc0, d;
    for (int i = 0; i < 1024; i++) mem_arr[i] = '0;
    mem_arr['h100] = 16'hABCD; mem_arr['h101] = 16'hEF80;
    mem_arr['h102] = 16'h1234; mem_arr['h103] = 16'h5681;
    mem_arr['h104] = 16'h0000; mem_arr['h105] = 16'h0080;
    mem_arr['h200] = 16'h1111; mem_arr['h201] = 16'h2281;
    mem_arr['h202] = 16'h3333; mem_arr['h203] = 16'h4480;
    mem_arr['h204] = 16'h5555; mem_arr['h205] = 16'h0000;
    mem_arr['h3FF] = 16'h1357; mem_arr['h000] = 16'h9B81;

    repeat (3) @(negedge clock);
    #2;
    check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Three records, zero waits; a second start mid-run must be ignored.
    dc0 = done_cnt;
    launch(20'h00100, 3, 0, st);
    chk("model_rec0", 32'(exp_q[0]), 32'h0ABCDEF);
    chk("model_rec1", 32'(exp_q[1]), 32'h1123456);
    chk("model_rec2", 32'(exp_q[2]), 32'h0000000);
    repeat (2) @(negedge clock);
    base_addr = 20'h00000; num_records = 16'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(dc0);
    chk("a_rec_count", 32'(rec_count), 32'd3);
    chk("a_fail_count", 32'(fail_count), 32'd1);
    chk("a_first_read_lat", 32'(first_rd_cyc - st), 32'd1);
    chk("a_done_lat", 32'(done_cyc - first_rd_cyc), 32'd12);
    chk("a_done_pulses", 32'(done_cnt - dc0), 32'd1);

    // Same data, three wait states on every access.
    dc0 = done_cnt;
    launch(20'h00100, 3, 3, st);
    wait_done(dc0);
    chk("b_rec_count", 32'(rec_count), 32'd3);
    chk("b_fail_count", 32'(fail_count), 32'd1);

    // Truncated run: third record lacks the run marker.
    dc0 = done_cnt;
    launch(20'h00200, 5, 0, st);
    chk("model_trunc", 32'(exp_trunc), 32'd1);
    wait_done(dc0);
    chk("c_truncated", 32'(truncated), 32'd1);
    chk("c_rec_count", 32'(rec_count), 32'd2);
    chk("c_fail_count", 32'(fail_count), 32'd1);
    chk("c_done_after_lo", 32'(done_cyc - last_lo_cyc), 32'd2);

    // Zero records: no traffic, counters and truncated cleared by the start.
    dc0 = done_cnt;
    launch(20'h00100, 0, 0, st);
    wait_done(dc0);
    d = done_cyc - st;
    chk("f_done_lat_window", 32'((d == 1) || (d == 2)), 32'd1);
    chk("f_no_mem_read", 32'(first_rd_cyc), 32'hFFFFFFFF);
    chk("f_truncated_cleared", 32'(truncated), 32'd0);
    chk("f_rec_count", 32'(rec_count), 32'd0);

    // FIFO full for the whole of the first PUSH (cycles st+4 .. st+13).
    dc0 = done_cnt;
    ofifo_wrfull = 1'b1;
    launch(20'h00100, 3, 0, st);
    for (int k = 2; k <= 14; k++) begin
      @(negedge clock);
      if (k == 14) ofifo_wrfull = 1'b0;
      #2;
      if (k >= 4 && k <= 13) begin
        chk("d_wrreq_held", 32'(ofifo_wrreq), 32'd0);
        chk("d_data_stable", 32'(ofifo_data), 32'h0ABCDEF);
      end
    end
    wait_done(dc0);
    chk("d_rec_count", 32'(rec_count), 32'd3);

    // Address wrap at the top of the SRAM.
    dc0 = done_cnt;
    launch(20'hFFFFF, 1, 0, st);
    chk("model_wrap_addr", 32'(exp_addr_q[1]), 32'h00000);
    chk("model_wrap_rec", 32'(exp_q[0]), 32'h113579B);
    wait_done(dc0);
    chk("e_rec_count", 32'(rec_count), 32'd1);
    chk("e_fail_count", 32'(fail_count), 32'd1);

    // Reset while the second word read is stalled.
    dc0 = done_cnt;
    launch(20'h00100, 3, 3, st);
    for (int k = 0; k < 50 && acc_cnt < 1; k++) @(negedge clock);
    chk("r_reached_rd_lo", 32'(acc_cnt), 32'd1);
    @(negedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    repeat (3) @(negedge clock);
    chk("r_no_done", 32'(done_cnt - dc0), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    chk("r_idle_after_reset", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
